// File: rtl/apb_timer_ch.sv
// APB timer channel: CNT_W-bit up/down counter with prescaler, auto-reload, sticky flags and level IRQ.
// Optional compare-match register and flag are built only when `TMR_CMP_MATCH_EN is defined.
module apb_timer_ch #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [CNT_W-1:0]  pwdata,
  output logic [CNT_W-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              tmr_irq
);

`ifdef TMR_CMP_MATCH_EN
  localparam logic [2:0] FLAG_MASK = 3'b111;
`else
  localparam logic [2:0] FLAG_MASK = 3'b011;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] tdr_q, tcnt_q, tcnt_d;
  logic [2:0]       clk_sel_q, tsr_q, tsr_d, tier_q, flag_set;
  logic             en_q, dw_q, arl_q, load_q, irq_q;
  logic [7:0]       presc_q, presc_mask;
  logic             access, wr_en, tick, count_en, ovf_evt, udf_evt, cmp_evt;
  logic             sel_tdr, sel_tcr, sel_tsr, sel_tier, sel_tcnt, sel_tcmp, mapped;
`ifdef TMR_CMP_MATCH_EN
  logic [CNT_W-1:0] tcmp_q;
`endif

  assign access   = psel & penable;
  assign wr_en    = access & pwrite;
  assign sel_tdr  = (paddr == ADDR_W'(0));
  assign sel_tcr  = (paddr == ADDR_W'(1));
  assign sel_tsr  = (paddr == ADDR_W'(2));
  assign sel_tier = (paddr == ADDR_W'(3));
  assign sel_tcnt = (paddr == ADDR_W'(4));
`ifdef TMR_CMP_MATCH_EN
  assign sel_tcmp = (paddr == ADDR_W'(5));
`else
  assign sel_tcmp = 1'b0;
`endif
  assign mapped   = sel_tdr | sel_tcr | sel_tsr | sel_tier | sel_tcnt | sel_tcmp;

  assign pready  = 1'b1;
  assign pslverr = access & (~mapped | (pwrite & sel_tcnt));
  assign tmr_irq = irq_q;

  always_comb begin
    prdata = '0;
    if (access && !pwrite) begin
      if (sel_tdr)  prdata = tdr_q;
      if (sel_tcr)  prdata = CNT_W'({load_q, arl_q, dw_q, en_q, 1'b0, clk_sel_q});
      if (sel_tsr)  prdata = CNT_W'(tsr_q);
      if (sel_tier) prdata = CNT_W'(tier_q);
      if (sel_tcnt) prdata = tcnt_q;
`ifdef TMR_CMP_MATCH_EN
      if (sel_tcmp) prdata = tcmp_q;
`endif
    end
  end

  // Tick fires when the low clk_sel+1 prescaler bits are all ones: divide by 2^(clk_sel+1).
  assign presc_mask = 8'((9'd2 << clk_sel_q) - 9'd1);
  assign count_en   = en_q & ~load_q;
  assign tick       = count_en & ((presc_q & presc_mask) == presc_mask);

  always_comb begin
    tcnt_d  = tcnt_q;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (load_q) begin
      tcnt_d = tdr_q;
    end else if (tick) begin
      if (!dw_q) begin
        if (tcnt_q == CNT_MAX) begin
          tcnt_d  = arl_q ? tdr_q : '0;
          ovf_evt = 1'b1;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end else begin
        if (tcnt_q == '0) begin
          tcnt_d  = arl_q ? tdr_q : CNT_MAX;
          udf_evt = 1'b1;
        end else begin
          tcnt_d = tcnt_q - CNT_W'(1);
        end
      end
    end
  end

`ifdef TMR_CMP_MATCH_EN
  assign cmp_evt = tick & (tcnt_d == tcmp_q);
`else
  assign cmp_evt = 1'b0;
`endif
  assign flag_set = {cmp_evt, udf_evt, ovf_evt};

  // Software write-0-clear is applied first so a coincident hardware set wins.
  always_comb begin
    tsr_d = tsr_q;
    if (wr_en && sel_tsr) tsr_d = tsr_q & pwdata[2:0];
    tsr_d = (tsr_d | flag_set) & FLAG_MASK;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr_q     <= '0;
      tcnt_q    <= '0;
      clk_sel_q <= '0;
      en_q      <= 1'b0;
      dw_q      <= 1'b0;
      arl_q     <= 1'b0;
      load_q    <= 1'b0;
      tsr_q     <= '0;
      tier_q    <= '0;
      presc_q   <= '0;
      irq_q     <= 1'b0;
`ifdef TMR_CMP_MATCH_EN
      tcmp_q    <= '0;
`endif
    end else begin
      tcnt_q  <= tcnt_d;
      tsr_q   <= tsr_d;
      presc_q <= count_en ? presc_q + 8'd1 : 8'd0;
      irq_q   <= |(tsr_q & tier_q);
      if (wr_en && sel_tdr) tdr_q <= pwdata;
      if (wr_en && sel_tcr) begin
        clk_sel_q <= pwdata[2:0];
        en_q      <= pwdata[4];
        dw_q      <= pwdata[5];
        arl_q     <= pwdata[6];
        load_q    <= pwdata[7];
      end
      if (wr_en && sel_tier) tier_q <= pwdata[2:0] & FLAG_MASK;
`ifdef TMR_CMP_MATCH_EN
      if (wr_en && sel_tcmp) tcmp_q <= pwdata;
`endif
    end
  end

endmodule

// File: tb/tb_apb_timer_ch.sv
// Testbench for apb_timer_ch (CNT_W=8): directed APB sequences checked against a cycle-level
// behavioural model of the timer; also exercises the `TMR_CMP_MATCH_EN build when defined.
module tb_apb_timer_ch;

  localparam int CNT_W  = 8;
  localparam int ADDR_W = 8;
  localparam int MAXV   = 255;
`ifdef TMR_CMP_MATCH_EN
  localparam logic [2:0] MMASK = 3'b111;
`else
  localparam logic [2:0] MMASK = 3'b011;
`endif

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [CNT_W-1:0]  pwdata = '0;
  logic [CNT_W-1:0]  prdata;
  logic              pready;
  logic              pslverr;
  logic              tmr_irq;

  int total = 0;
  int bad   = 0;

  apb_timer_ch #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tmr_irq (tmr_irq)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain integers; the prescaler is a count of
  // enabled cycles and the counter wraps by range check on ordinary arithmetic.
  int         mTdr, mTcnt, mTcmp, mEcount;
  logic [7:0] mTcr;
  logic [2:0] mTsr, mTier;
  logic       mIrq;

  always @(posedge pclk or negedge presetn) begin : modelStep
    int         div, nextCnt;
    bit         counting, tick;
    logic [2:0] sets, nextTsr;
    logic       nextIrq;
    if (!presetn) begin
      mTdr = 0; mTcnt = 0; mTcmp = 0; mEcount = 0;
      mTcr = '0; mTsr = '0; mTier = '0; mIrq = 1'b0;
    end else begin
      div      = 2 << mTcr[2:0];
      counting = mTcr[4] && !mTcr[7];
      tick     = counting && ((mEcount % div) == div - 1);
      nextCnt  = mTcnt;
      sets     = '0;
      if (mTcr[7]) begin
        nextCnt = mTdr;
      end else if (tick) begin
        nextCnt = mTcr[5] ? mTcnt - 1 : mTcnt + 1;
        if (nextCnt > MAXV) begin
          nextCnt = mTcr[6] ? mTdr : 0;
          sets[0] = 1'b1;
        end else if (nextCnt < 0) begin
          nextCnt = mTcr[6] ? mTdr : MAXV;
          sets[1] = 1'b1;
        end
`ifdef TMR_CMP_MATCH_EN
        if (nextCnt == mTcmp) sets[2] = 1'b1;
`endif
      end
      nextIrq = |(mTsr & mTier);
      nextTsr = mTsr;
      if (psel && penable && pwrite) begin
        case (paddr)
          8'h00: mTdr = int'(pwdata);
          8'h01: mTcr = pwdata;
          8'h02: nextTsr = mTsr & pwdata[2:0];
          8'h03: mTier = pwdata[2:0] & MMASK;
`ifdef TMR_CMP_MATCH_EN
          8'h05: mTcmp = int'(pwdata);
`endif
          default: ;
        endcase
      end
      mTsr    = (nextTsr | sets) & MMASK;
      mTcnt   = nextCnt;
      mIrq    = nextIrq;
      mEcount = counting ? (mEcount + 1) % 256 : 0;
    end
  end

  function automatic void expRead(input logic [7:0] a, output logic [7:0] d, output logic e);
    d = '0;
    e = 1'b0;
    case (a)
      8'h00: d = mTdr[7:0];
      8'h01: d = mTcr & 8'hF7;
      8'h02: d = {5'b0, mTsr};
      8'h03: d = {5'b0, mTier};
      8'h04: d = mTcnt[7:0];
`ifdef TMR_CMP_MATCH_EN
      8'h05: d = mTcmp[7:0];
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Mid-cycle comparison of every output against the model.
  always @(negedge pclk) begin : compareStep
    logic [7:0] ed;
    logic       ee;
    if (presetn) begin
      checkOutput("pready", int'(pready), 1);
      checkOutput("tmr_irq", int'(tmr_irq), int'(mIrq));
      if (psel && penable) begin
        expRead(paddr, ed, ee);
        if (!pwrite) checkOutput("prdata", int'(prdata), int'(ed));
        checkOutput("pslverr", int'(pslverr), int'(ee | (pwrite && paddr == 8'h04)));
      end else begin
        checkOutput("pslverr_idle", int'(pslverr), 0);
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [7:0] d,
                               output logic [7:0] rd, output logic err);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    rd  = prdata;
    err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic       err;
    applyStimulus(1'b1, a, d, rd, err);
  endtask

  task automatic readExpect(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] rd;
    logic       err;
    applyStimulus(1'b0, a, 8'h00, rd, err);
    checkOutput(name, int'(rd), int'(exp));
  endtask

  initial begin : mainSeq
    logic [7:0] rd;
    logic       err;

    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("rst_irq", int'(tmr_irq), 0);
    checkOutput("rst_pready", int'(pready), 1);
    checkOutput("rst_prdata", int'(prdata), 0);
    presetn = 1'b1;
    readExpect("rst_tdr", 8'h00, 8'h00);
    readExpect("rst_tcr", 8'h01, 8'h00);
    readExpect("rst_tsr", 8'h02, 8'h00);
    readExpect("rst_tier", 8'h03, 8'h00);
    readExpect("rst_tcnt", 8'h04, 8'h00);

    $display("[TB] up count, divide by 4");
    writeReg(8'h01, 8'h11);
    repeat (880) @(posedge pclk);
    readExpect("up_tsr_early", 8'h02, 8'h00);
    repeat (200) @(posedge pclk);
    readExpect("up_tsr_ovf", 8'h02, 8'h01);
    writeReg(8'h02, 8'h00);
    readExpect("up_tsr_clr", 8'h02, 8'h00);

    $display("[TB] down count, divide by 2, from 3");
    writeReg(8'h00, 8'h03);
    writeReg(8'h01, 8'h80);
    writeReg(8'h01, 8'h30);
    readExpect("dn_tsr_early", 8'h02, 8'h00);
    repeat (3) @(posedge pclk);
    writeReg(8'h01, 8'h20);
    readExpect("dn_tcnt_wrap", 8'h04, 8'hFF);
    readExpect("dn_tsr_udf", 8'h02, 8'h02);
    writeReg(8'h02, 8'h00);

    $display("[TB] auto-reload up from 0xFA");
    writeReg(8'h00, 8'hFA);
    writeReg(8'h01, 8'h80);
    writeReg(8'h01, 8'h50);
    repeat (10) @(posedge pclk);
    writeReg(8'h01, 8'h40);
    readExpect("arl_tcnt", 8'h04, 8'hFA);
    readExpect("arl_tsr", 8'h02, 8'h01);
    checkOutput("arl_irq_masked", int'(tmr_irq), 0);
    writeReg(8'h03, 8'h01);
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("arl_irq_on", int'(tmr_irq), 1);
    writeReg(8'h02, 8'h00);
    writeReg(8'h03, 8'h00);

    $display("[TB] set/clear race on overflow");
    writeReg(8'h01, 8'h80);
    writeReg(8'h01, 8'h50);
    repeat (9) @(posedge pclk);
    writeReg(8'h02, 8'h00);
    readExpect("race_tsr", 8'h02, 8'h01);
    writeReg(8'h01, 8'h00);
    writeReg(8'h02, 8'h00);

    $display("[TB] unmapped offset");
    applyStimulus(1'b0, 8'h07, 8'h00, rd, err);
    checkOutput("unm_rd_data", int'(rd), 0);
    checkOutput("unm_rd_err", int'(err), 1);
    applyStimulus(1'b1, 8'h07, 8'h55, rd, err);
    checkOutput("unm_wr_err", int'(err), 1);
    readExpect("unm_tdr_kept", 8'h00, 8'hFA);

`ifdef TMR_CMP_MATCH_EN
    $display("[TB] compare match at 0x10");
    writeReg(8'h05, 8'h10);
    readExpect("cmp_tcmp", 8'h05, 8'h10);
    writeReg(8'h00, 8'h00);
    writeReg(8'h01, 8'h80);
    writeReg(8'h01, 8'h10);
    repeat (34) @(posedge pclk);
    readExpect("cmp_tsr", 8'h02, 8'h04);
    readExpect("cmp_tcnt_runs", 8'h04, 8'h13);
    writeReg(8'h01, 8'h00);
    writeReg(8'h02, 8'h00);
`else
    $display("[TB] compare register absent");
    applyStimulus(1'b0, 8'h05, 8'h00, rd, err);
    checkOutput("nocmp_rd_data", int'(rd), 0);
    checkOutput("nocmp_rd_err", int'(err), 1);
    writeReg(8'h03, 8'h07);
    readExpect("nocmp_tier", 8'h03, 8'h03);
    writeReg(8'h03, 8'h00);
`endif

    $display("[TB] reset pulse mid-count");
    writeReg(8'h01, 8'h11);
    repeat (50) @(posedge pclk);
    #3 presetn = 1'b0;
    #4 presetn = 1'b1;
    readExpect("prst_tdr", 8'h00, 8'h00);
    readExpect("prst_tcr", 8'h01, 8'h00);
    repeat (20) @(posedge pclk);
    readExpect("prst_tcnt", 8'h04, 8'h00);
    readExpect("prst_tsr", 8'h02, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
